// File: rtl/alu_sequencer.sv
// Request sequencer for a multi-cycle external ALU. It holds operands stable for the
// opcode's settle time, captures the result and updates HI/LO for multiply and divide.
module alu_sequencer #(
    parameter int unsigned DIV_CYCLES = 4,
    parameter int unsigned MUL_CYCLES = 2,
    parameter logic [4:0]  MUL_OP     = 5'b00010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [63:0] alu_c,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_result,
    output logic        resp_err,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg,
    output logic        busy
);
    localparam logic [4:0] DIV_OP = 5'b00011;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] result_q, result_d;
    logic        err_q, err_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        is_illegal, is_div, is_mul, fault, wide_op;
    logic [3:0]  lat_m1;

    // Classify the incoming opcode; the upper half of the opcode space is illegal.
    always_comb begin
        is_illegal = req_op[4];
        is_div     = !is_illegal && (req_op == DIV_OP);
        is_mul     = !is_illegal && !is_div && (req_op == MUL_OP);
        fault      = is_illegal || (is_div && (req_b == '0));
        if (is_div)      lat_m1 = 4'(DIV_CYCLES - 1);
        else if (is_mul) lat_m1 = 4'(MUL_CYCLES - 1);
        else             lat_m1 = '0;
    end

    assign wide_op = (req_q.op == DIV_OP) || (req_q.op == MUL_OP);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = '{op: req_op, a: req_a, b: req_b};
                    if (fault) begin
                        // Faulting requests never reach the ALU.
                        state_d  = RESP;
                        result_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        state_d = EXEC;
                        cnt_d   = lat_m1;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    result_d = alu_c;
                    err_d    = 1'b0;
                    if (wide_op) begin
                        hi_d = alu_c[63:32];
                        lo_d = alu_c[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign busy        = (state_q != IDLE);
    assign alu_op      = (state_q == EXEC) ? req_q.op : '0;
    assign alu_a       = (state_q == EXEC) ? req_q.a  : '0;
    assign alu_b       = (state_q == EXEC) ? req_q.b  : '0;
    assign resp_result = result_q;
    assign resp_err    = err_q;
    assign hi_reg      = hi_q;
    assign lo_reg      = lo_q;
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DIV_CYCLES, default 4, ALU settle cycles held for divide (legal 1-15).
REQ-002 Parameter MUL_CYCLES, default 2, ALU settle cycles held for multiply (legal 1-15).
REQ-003 Parameter MUL_OP, default 5'b00010, opcode treated as multiply.
REQ-004 The block SHALL have one clock and a synchronous active-low reset.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_op  in  5  ALU opcode.
REQ-010 req_a, req_b  in  32 each  operands.
REQ-011 alu_a, alu_b  out  32 each  operands driven to ALU.
REQ-012 alu_op  out  5  opcode driven to ALU.
REQ-013 alu_c  in  64  ALU result.
REQ-014 resp_valid  out  1  result available.
REQ-015 resp_ready  in  1  consumer accepts result.
REQ-016 resp_result  out  64  captured result.
REQ-017 resp_err  out  1  request was illegal opcode or divide-by-zero.
REQ-018 hi_reg, lo_reg  out  32 each  architectural HI/LO registers.
REQ-019 busy  out  1  high whenever state != IDLE.

Function
REQ-020 FSM states SHALL be IDLE, EXEC, RESP; req_ready = (state==IDLE).
REQ-021 Accept on rising edge with req_valid && req_ready; op, a, b registered at that edge.
REQ-022 Opcode class: DIV = 5'b00011 (latency DIV_CYCLES), MUL = MUL_OP (MUL_CYCLES), 5'b10000-5'b11111 illegal, all others single (1 cycle).
REQ-023 Legal, non-faulting request: IDLE->EXEC, wait counter loaded with latency-1.
REQ-024 In EXEC, alu_a/alu_b/alu_op SHALL equal the registered request, stable every EXEC cycle; counter decrements each cycle.
REQ-025 At the edge where counter==0 in EXEC: resp_result <= alu_c, resp_err <= 0, EXEC->RESP.
REQ-026 Latency: resp_valid first high L+1 cycles after accept edge (L = class latency).
REQ-027 Illegal opcode, or DIV with req_b==0: IDLE->RESP directly, resp_result <= 0, resp_err <= 1, ALU not driven, HI/LO unchanged; resp_valid high 1 cycle after accept.
REQ-028 At capture edge for MUL or DIV only: hi_reg <= alu_c[63:32], lo_reg <= alu_c[31:0]; other ops leave HI/LO unchanged.
REQ-029 resp_valid = (state==RESP); resp_result/resp_err held stable while resp_valid && !resp_ready.
REQ-030 RESP->IDLE on edge with resp_ready; no request accepted that same edge (next accept earliest one cycle later).
REQ-031 In IDLE and RESP, alu_a, alu_b, alu_op SHALL be driven to 0.
REQ-032 req_valid while not IDLE SHALL be ignored (no state effect); requester holds it.

Reset
REQ-033 rst_n low at edge: state IDLE, counter 0, resp_result 0, resp_err 0, hi_reg 0, lo_reg 0, registered operands 0; outputs reflect IDLE next cycle.
REQ-034 Reset mid-EXEC or mid-RESP aborts the operation; no response, HI/LO cleared to 0.

Verification
REQ-035 DIV a=100, b=7, DIV_CYCLES=4 -> alu_op=00011 held 4 cycles, resp_valid at accept+5, hi_reg/lo_reg = alu_c halves, resp_err=0.
REQ-036 Shift op 5'b00100 a=3, b=1 -> resp_valid at accept+2, resp_result = alu_c, HI/LO unchanged.
REQ-037 DIV b=0 -> resp_valid at accept+1, resp_err=1, resp_result=0, alu_op stays 0, HI/LO unchanged.
REQ-038 op=5'b10101 -> resp_err=1, resp_result=0; resp_ready held low 3 cycles -> result stable, req_ready=0 throughout.
REQ-039 MUL accepted, rst_n low during second EXEC cycle -> IDLE next cycle, no resp_valid, hi_reg=lo_reg=0.
REQ-040 Back-to-back requests with resp_ready=1 -> second accept exactly one cycle after RESP->IDLE edge.
